// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and decode channels of the fetch unit
//
// Purpose: bundles the instruction-memory request/response channel and the
//          decode-side valid/ready channel of instr_fetch_unit.
// Signals:
//   imem_req_valid/imem_req_ready/imem_req_addr  request channel (fetch -> memory)
//   imem_rsp_valid/imem_rsp_data                 in-order response (memory -> fetch)
//   if_valid/if_ready/if_instr/if_pc/if_opcode   instruction channel (fetch -> decode)
// Modports: master = fetch unit side, slave = memory/decode side.

interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [6:0]      if_opcode;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output if_valid,
        output if_instr,
        output if_pc,
        output if_opcode,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_opcode,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch with show-ahead buffer and redirect flush
//
// Purpose: holds the fetch PC, issues word requests to instruction memory,
//          buffers returned words with their PC and presents them to decode.
//          Branch redirects flush the buffer and drain in-flight responses.
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   bus             instr_fetch_unit_if.master (memory request/response, decode channel)
//   redirect_valid  taken branch/jump, flush
//   redirect_pc     new fetch PC (low two bits ignored)
//   perf_fetch_cnt  decode pops, saturating      (only with IFU_PERF_CNT_EN)
//   perf_flush_cnt  redirect cycles, saturating  (only with IFU_PERF_CNT_EN)
// Optional feature macro: IFU_PERF_CNT_EN
// XLEN must match the XLEN of the connected interface instance.

module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_unit_if.master     bus,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL_V  = CW'(DEPTH);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   out_q, out_d;

    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_pc_q   [DEPTH];
    logic [AW-1:0]   fifo_rd_q, fifo_rd_d;
    logic [AW-1:0]   fifo_wr_q, fifo_wr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

    // PC of every outstanding request, oldest first
    logic [XLEN-1:0] pcq_q [DEPTH];
    logic [AW-1:0]   pcq_rd_q, pcq_rd_d;
    logic [AW-1:0]   pcq_wr_q, pcq_wr_d;

    logic            fifo_empty;
    logic            pop;
    logic            rsp_seen;
    logic            push;
    logic            req_valid;
    logic            req_fire;
    logic [CW:0]     occupancy;

    logic            unused_ok;
    assign unused_ok = ^redirect_pc[1:0];

    assign fifo_empty = (fifo_cnt_q == '0);
    // A redirect flushes the head, so a handshake in that cycle is not a pop
    assign pop        = rst_n && !fifo_empty && bus.if_ready && !redirect_valid;
    // Guard against a stray response with nothing outstanding
    assign rsp_seen   = bus.imem_rsp_valid && (out_q != '0);
    assign push       = rsp_seen && (state_q == ST_RUN) && !redirect_valid;

    // Credit counts the slot freed by a same-cycle pop so that a steady
    // stream issues one request per cycle without ever overfilling the buffer
    assign occupancy  = {1'b0, out_q} + {1'b0, fifo_cnt_q} - (CW+1)'(pop);
    assign req_valid  = rst_n && (state_q == ST_RUN) && !redirect_valid && (occupancy < DEPTH_V);
    assign req_fire   = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;

    assign bus.if_valid  = rst_n && !fifo_empty;
    assign bus.if_instr  = bus.if_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign bus.if_pc     = bus.if_valid ? fifo_pc_q[fifo_rd_q]   : '0;
    assign bus.if_opcode = bus.if_instr[6:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + CW'(req_fire) - CW'(rsp_seen);
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            state_d    = (out_d != '0) ? ST_DRAIN : ST_RUN;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
            pcq_rd_d   = '0;
            pcq_wr_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (req_fire) begin
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                        pcq_wr_d   = pcq_wr_q + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
            endcase
            if (push) begin
                fifo_wr_d = fifo_wr_q + AW'(1);
                pcq_rd_d  = pcq_rd_q + AW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + AW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    // Storage arrays need no reset: every read is qualified by a count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[fifo_wr_q] <= bus.imem_rsp_data;
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        end
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
    end

    // The credit rule makes a push into a full buffer without a pop impossible
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fifo_cnt_q == FULL_V) && !pop));

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pop && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (redirect_valid && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = 32'h0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cyc   = 0;
    int fires = 0;
    int f0;
    int pops;
    int due_q[$];
    logic [31:0] dat_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus();

    assign bus.imem_rsp_valid = mem_rsp_valid;
    assign bus.imem_rsp_data  = mem_rsp_data;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00B5_0533 : ((a << 8) | 32'h13);
    endfunction

    // Instruction memory: in-order responses, lat cycles after acceptance,
    // squashed by reset
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            due_q.delete();
            dat_q.delete();
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            due_q.push_back(cyc + lat - 1);
            dat_q.push_back(mem_word(bus.imem_req_addr));
            fires = fires + 1;
        end
        #1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = dat_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        lat                = 1;

        // Reset cycle outputs
        step; step; #1;
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("rst_if_valid",  {31'b0, bus.if_valid},       32'h0);
        chk("rst_if_instr",  bus.if_instr,                32'h0);
        chk("rst_if_pc",     bus.if_pc,                   32'h0);
        chk("rst_if_opcode", {25'b0, bus.if_opcode},      32'h0);

        // Streaming fetch, 1-cycle memory, decode always ready
        rst_n = 1'b1; #1;
        chk("s_c0_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("s_c0_req_addr",  bus.imem_req_addr,           32'h0);
        step; #1;
        chk("s_c1_req_addr",  bus.imem_req_addr,           32'h4);
        chk("s_c1_if_valid",  {31'b0, bus.if_valid},       32'h0);
        step; #1;
        chk("s_c2_if_valid",  {31'b0, bus.if_valid},       32'h1);
        chk("s_c2_if_pc",     bus.if_pc,                   32'h0);
        chk("s_c2_if_instr",  bus.if_instr,                32'h00B5_0533);
        chk("s_c2_opcode",    {25'b0, bus.if_opcode},      32'h33);
        chk("s_c2_req_addr",  bus.imem_req_addr,           32'h8);
        step; #1;
        chk("s_c3_if_pc",     bus.if_pc,                   32'h4);
        chk("s_c3_if_instr",  bus.if_instr,                32'h0000_0413);
        chk("s_c3_req_addr",  bus.imem_req_addr,           32'hC);
        step; #1;
        chk("s_c4_if_pc",     bus.if_pc,                   32'h8);

        // Decode stalled for 5 cycles
        rst_n = 1'b0; bus.if_ready = 1'b0;
        step; step;
        rst_n = 1'b1;
        f0 = fires;
        step; step; #1;
        chk("st_c2_if_valid", {31'b0, bus.if_valid},       32'h1);
        chk("st_c2_if_pc",    bus.if_pc,                   32'h0);
        step; step; #1;
        chk("st_req_count",   32'(fires - f0),             32'd2);
        chk("st_c4_req_valid",{31'b0, bus.imem_req_valid}, 32'h0);
        chk("st_c4_if_pc",    bus.if_pc,                   32'h0);
        chk("st_c4_if_instr", bus.if_instr,                32'h00B5_0533);
        step;
        bus.if_ready = 1'b1; #1;
        chk("st_c5_if_pc",    bus.if_pc,                   32'h0);
        chk("st_c5_req_addr", bus.imem_req_addr,           32'h8);
        step; #1;
        chk("st_c6_if_pc",    bus.if_pc,                   32'h4);
        step; #1;
        chk("st_c7_if_pc",    bus.if_pc,                   32'h8);
        step; #1;
        chk("st_c8_if_pc",    bus.if_pc,                   32'hC);

        // Redirect to misaligned 0x103 with two responses in flight
        rst_n = 1'b0; lat = 3;
        step; step;
        rst_n = 1'b1; #1;
        chk("rd_c0_req_addr", bus.imem_req_addr,           32'h0);
        step; #1;
        chk("rd_c1_req_addr", bus.imem_req_addr,           32'h4);
        step;
        redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        chk("rd_c2_req_valid",{31'b0, bus.imem_req_valid}, 32'h0);
        step;
        redirect_valid = 1'b0; lat = 1; #1;
        chk("rd_c3_req_valid",{31'b0, bus.imem_req_valid}, 32'h0);
        chk("rd_c3_if_valid", {31'b0, bus.if_valid},       32'h0);
        step; #1;
        chk("rd_c4_req_valid",{31'b0, bus.imem_req_valid}, 32'h0);
        chk("rd_c4_if_valid", {31'b0, bus.if_valid},       32'h0);
        step; #1;
        chk("rd_c5_req_valid",{31'b0, bus.imem_req_valid}, 32'h1);
        chk("rd_c5_req_addr", bus.imem_req_addr,           32'h100);
        step; #1;
        chk("rd_c6_if_valid", {31'b0, bus.if_valid},       32'h0);
        chk("rd_c6_req_addr", bus.imem_req_addr,           32'h104);
        step; #1;
        chk("rd_c7_if_pc",    bus.if_pc,                   32'h100);
        chk("rd_c7_if_instr", bus.if_instr,                32'h0001_0013);

        // Redirect together with a pop and an arriving response
        redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("cc_req_valid",   {31'b0, bus.imem_req_valid}, 32'h0);
        step;
        redirect_valid = 1'b0; #1;
        chk("cc_c1_if_valid", {31'b0, bus.if_valid},       32'h0);
        chk("cc_c1_req_addr", bus.imem_req_addr,           32'h200);
        step; #1;
        chk("cc_c2_if_valid", {31'b0, bus.if_valid},       32'h0);
        step; #1;
        chk("cc_c3_if_pc",    bus.if_pc,                   32'h200);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step;
        redirect_valid = 1'b0; #1;
        chk("wr_req_addr0",   bus.imem_req_addr,           32'hFFFF_FFFC);
        chk("wr_if_valid",    {31'b0, bus.if_valid},       32'h0);
        step; #1;
        chk("wr_req_addr1",   bus.imem_req_addr,           32'h0);
        step; #1;
        chk("wr_if_pc0",      bus.if_pc,                   32'hFFFF_FFFC);
        chk("wr_if_instr0",   bus.if_instr,                32'hFFFF_FC13);
        step; #1;
        chk("wr_if_pc1",      bus.if_pc,                   32'h0);

`ifdef IFU_PERF_CNT_EN
        // Performance counters: 10 pops, 3 redirect cycles, then reset
        rst_n = 1'b0;
        step; step; #1;
        chk("pf_rst_fetch",   perf_fetch_cnt,              32'd0);
        chk("pf_rst_flush",   perf_flush_cnt,              32'd0);
        rst_n = 1'b1; bus.if_ready = 1'b1; pops = 0;
        for (int i = 0; i < 40 && pops < 10; i++) begin
            step; #1;
            if (bus.if_valid && bus.if_ready) pops = pops + 1;
        end
        chk("pf_pop_budget",  32'(pops),                   32'd10);
        step;
        bus.if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step; step; step;
        redirect_valid = 1'b0; #1;
        chk("pf_fetch_cnt",   perf_fetch_cnt,              32'd10);
        chk("pf_flush_cnt",   perf_flush_cnt,              32'd3);
        rst_n = 1'b0;
        step; #1;
        chk("pf_clr_fetch",   perf_fetch_cnt,              32'd0);
        chk("pf_clr_flush",   perf_flush_cnt,              32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
